// File: rtl/div_sched.sv
// Sequencing controller for the iterative RV32M divider: resolves special
// cases, drives the shared datapath, holds the pipeline and sign-corrects.
module div_sched #(
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        div_req_ex_i,
  input  logic [1:0]  div_op_ex_i,
  input  logic [31:0] op_a_ex_i,
  input  logic [31:0] op_b_ex_i,
  input  logic        flush_ex_i,
  input  logic        stall_ex_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] rem_i,
  output logic        div_start_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_step_o,
  output logic        stall_div_o,
  output logic        res_valid_o,
  output logic [31:0] res_o,
  output logic        abort_o
);

  localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             valid_q;
  logic             rem_q;
  logic             neg_a_q;
  logic             neg_q_q;
  logic             spec_q;
  logic [31:0]      spec_res_q;

  logic        signed_op;
  logic        is_rem;
  logic        neg_a;
  logic        neg_b;
  logic        neg_q;
  logic        b_zero;
  logic        ovf;
  logic        special;
  logic [31:0] spec_val;
  logic        accept;
  logic [31:0] sel_mag;
  logic        sel_neg;
  logic [31:0] corr_res;

  // Operand decode, special-case detection and magnitude conversion
  always_comb begin
    signed_op = ~div_op_ex_i[0];
    is_rem    = div_op_ex_i[1];
    neg_a     = signed_op & op_a_ex_i[31];
    neg_b     = signed_op & op_b_ex_i[31];
    neg_q     = neg_a ^ neg_b;
    b_zero    = (op_b_ex_i == 32'h0);
    ovf       = signed_op && (op_a_ex_i == 32'h8000_0000) && (op_b_ex_i == 32'hFFFF_FFFF);
    special   = b_zero | ovf;
    if (b_zero) begin
      spec_val = is_rem ? op_a_ex_i : 32'hFFFF_FFFF;
    end else begin
      spec_val = is_rem ? 32'h0 : 32'h8000_0000;
    end
    div_a_o     = neg_a ? 32'(32'h0 - op_a_ex_i) : op_a_ex_i;
    div_b_o     = neg_b ? 32'(32'h0 - op_b_ex_i) : op_b_ex_i;
    accept      = (state_q == ST_IDLE) & div_req_ex_i & ~flush_ex_i & ~rst_i;
    div_start_o = accept & ~special;
    stall_div_o = accept | (state_q == ST_BUSY);
  end

  // A flush kills the in-flight iteration and raises a one-cycle abort
  always_comb begin
    div_step_o = step_q & ~flush_ex_i;
    abort_o    = (state_q != ST_IDLE) & flush_ex_i & ~rst_i;
  end

  // Result selection and sign correction from the datapath magnitudes
  always_comb begin
    sel_mag     = rem_q ? rem_i : quot_i;
    sel_neg     = rem_q ? neg_a_q : neg_q_q;
    corr_res    = sel_neg ? 32'(32'h0 - sel_mag) : sel_mag;
    res_valid_o = valid_q;
    if (valid_q) begin
      res_o = spec_q ? spec_res_q : corr_res;
    end else begin
      res_o = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      valid_q    <= 1'b0;
      rem_q      <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_q_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_q      <= is_rem;
            neg_a_q    <= neg_a;
            neg_q_q    <= neg_q;
            spec_q     <= special;
            spec_res_q <= spec_val;
            if (special) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= CNT_LOAD;
              step_q  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (flush_ex_i) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= ST_DONE;
            step_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (flush_ex_i || !stall_ex_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
